// File: rtl/a2bus_event_fifo.sv
// a2bus_event_fifo: address-filtered show-ahead event FIFO behind the Apple II bus interface.
// Define A2BUS_EVENT_FIFO_TIMESTAMP_EN to add a per-entry bus-cycle timestamp (bus_cycle_i / ev_ts_o).
module a2bus_event_fifo #(
    parameter int          DEPTH         = 16,
    parameter logic [15:0] ADDR_MATCH    = 16'hC000,
    parameter logic [15:0] ADDR_MASK     = 16'hFF00,
    parameter bit          CAPTURE_READS = 1'b0
) (
    input  logic                     clk_logic_i,
    input  logic                     system_reset_n_i,
    input  logic [15:0]              bus_addr_i,
    input  logic [7:0]               bus_data_i,
    input  logic                     bus_rw_n_i,
    input  logic                     bus_strobe_i,
    input  logic                     flush_i,
    output logic                     ev_valid_o,
    input  logic                     ev_ready_i,
    output logic [15:0]              ev_addr_o,
    output logic [7:0]               ev_data_o,
    output logic                     ev_rw_n_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o,
    output logic [7:0]               drop_count_o,
`ifdef A2BUS_EVENT_FIFO_TIMESTAMP_EN
    input  logic                     bus_cycle_i,
    output logic [15:0]              ev_ts_o,
`endif
    input  logic                     clear_overflow_i
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
`ifdef A2BUS_EVENT_FIFO_TIMESTAMP_EN
    localparam int EW = 41;
`else
    localparam int EW = 25;
`endif

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    drop_count_q, drop_count_d;
    logic          hit, pop, full, push, drop;
    logic [EW-1:0] entry, head;

`ifdef A2BUS_EVENT_FIFO_TIMESTAMP_EN
    logic [15:0] ts_q, ts_d;
    // Entries capture the pre-increment count when a cycle pulse coincides with the push
    assign ts_d  = bus_cycle_i ? ts_q + 16'd1 : ts_q;
    assign entry = {ts_q, bus_addr_i, bus_data_i, bus_rw_n_i};
    assign ev_ts_o = head[40:25];
    always_ff @(posedge clk_logic_i or negedge system_reset_n_i)
        if (!system_reset_n_i) ts_q <= '0;
        else ts_q <= ts_d;
`else
    assign entry = {bus_addr_i, bus_data_i, bus_rw_n_i};
`endif

    always_comb begin
        hit  = bus_strobe_i && ((bus_addr_i & ADDR_MASK) == (ADDR_MATCH & ADDR_MASK))
               && (!bus_rw_n_i || CAPTURE_READS);
        pop  = (count_q != '0) && ev_ready_i;
        full = count_q == CW'(DEPTH);
        push = hit && !flush_i && (!full || pop);
        drop = hit && !flush_i && full && !pop;
        wr_ptr_d = flush_i ? '0 : push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = flush_i ? '0 : pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = flush_i ? '0 : count_q + CW'(push) - CW'(pop);
        overflow_d   = drop || (overflow_q && !clear_overflow_i);
        drop_count_d = clear_overflow_i ? {7'd0, drop}
                     : (drop && drop_count_q != 8'hFF) ? drop_count_q + 8'd1 : drop_count_q;
    end

    always_ff @(posedge clk_logic_i or negedge system_reset_n_i)
        if (!system_reset_n_i) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end

    always_ff @(posedge clk_logic_i)
        if (push) mem_q[wr_ptr_q] <= entry;

    assign head = mem_q[rd_ptr_q];
    assign {ev_addr_o, ev_data_o, ev_rw_n_o} = head[24:0];
    assign ev_valid_o   = count_q != '0;
    assign count_o      = count_q;
    assign overflow_o   = overflow_q;
    assign drop_count_o = drop_count_q;
endmodule

// File: tb/tb_a2bus_event_fifo.sv
// tb_a2bus_event_fifo: queue-model scoreboard plus directed vectors for a2bus_event_fifo.
module tb_a2bus_event_fifo;
    logic        clk = 0, rst_n = 0;
    logic [15:0] addr = 0;
    logic [7:0]  data = 0;
    logic        rw = 0, strobe = 0, flush = 0, ready = 0, clr = 0;
    logic        valid, rw_o, ovf, valid_r, rw_r, ovf_r;
    logic [15:0] addr_o, addr_r;
    logic [7:0]  data_o, drop_o, data_r, drop_r;
    logic [4:0]  count_o, count_r;
    int passed = 0, total = 0;

    always #5 clk = ~clk;

    a2bus_event_fifo dut (
        .clk_logic_i(clk), .system_reset_n_i(rst_n), .bus_addr_i(addr), .bus_data_i(data),
        .bus_rw_n_i(rw), .bus_strobe_i(strobe), .flush_i(flush), .ev_valid_o(valid),
        .ev_ready_i(ready), .ev_addr_o(addr_o), .ev_data_o(data_o), .ev_rw_n_o(rw_o),
        .count_o(count_o), .overflow_o(ovf), .drop_count_o(drop_o),
`ifdef A2BUS_EVENT_FIFO_TIMESTAMP_EN
        .bus_cycle_i(1'b0), .ev_ts_o(),
`endif
        .clear_overflow_i(clr));

    a2bus_event_fifo #(.CAPTURE_READS(1'b1)) dut_r (
        .clk_logic_i(clk), .system_reset_n_i(rst_n), .bus_addr_i(addr), .bus_data_i(data),
        .bus_rw_n_i(rw), .bus_strobe_i(strobe), .flush_i(flush), .ev_valid_o(valid_r),
        .ev_ready_i(ready), .ev_addr_o(addr_r), .ev_data_o(data_r), .ev_rw_n_o(rw_r),
        .count_o(count_r), .overflow_o(ovf_r), .drop_count_o(drop_r),
`ifdef A2BUS_EVENT_FIFO_TIMESTAMP_EN
        .bus_cycle_i(1'b0), .ev_ts_o(),
`endif
        .clear_overflow_i(clr));

    typedef struct packed {logic [15:0] a; logic [7:0] d; logic r;} ev_t;
    ev_t q[$];
    bit  m_ovf, m_hit, m_pop, m_drop_now;
    int  m_drop;

    // Reference: writes to page C0xx only, 16-deep queue, saturating drop counter
    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            q.delete();
            m_ovf = 0;
            m_drop = 0;
        end else begin
            m_hit = strobe && addr[15:8] == 8'hC0 && !rw;
            m_pop = q.size() != 0 && ready;
            m_drop_now = m_hit && !flush && q.size() == 16 && !m_pop;
            if (flush) q.delete();
            else begin
                if (m_pop) void'(q.pop_front());
                if (m_hit && !m_drop_now) q.push_back('{addr, data, rw});
            end
            if (clr) begin
                m_ovf = m_drop_now;
                m_drop = m_drop_now ? 1 : 0;
            end else if (m_drop_now) begin
                m_ovf = 1;
                if (m_drop < 255) m_drop++;
            end
        end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        chk("m_count", 32'(count_o), q.size());
        chk("m_valid", 32'(valid), 32'(q.size() != 0));
        chk("m_ovf", 32'(ovf), 32'(m_ovf));
        chk("m_drop", 32'(drop_o), m_drop);
        if (q.size() != 0) begin
            chk("m_addr", 32'(addr_o), 32'(q[0].a));
            chk("m_data", 32'(data_o), 32'(q[0].d));
            chk("m_rw", 32'(rw_o), 32'(q[0].r));
        end
    end

    task automatic step(input logic s, input logic [15:0] a, input logic [7:0] d, input logic r,
                        input logic rdy, input logic fl, input logic cl);
        strobe = s; addr = a; data = d; rw = r; ready = rdy; flush = fl; clr = cl;
        @(negedge clk);
        strobe = 0; ready = 0; flush = 0; clr = 0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("rst_count", 32'(count_o), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_drop", 32'(drop_o), 0);
        // single write then pop
        step(1, 16'hC0A5, 8'h3C, 0, 0, 0, 0);
        chk("w_valid", 32'(valid), 1);
        chk("w_addr", 32'(addr_o), 32'hC0A5);
        chk("w_data", 32'(data_o), 32'h3C);
        chk("w_rw", 32'(rw_o), 0);
        chk("w_count", 32'(count_o), 1);
        step(0, 0, 0, 0, 1, 0, 0);
        chk("pop_valid", 32'(valid), 0);
        chk("pop_count", 32'(count_o), 0);
        // address and read filtering
        step(1, 16'hD000, 8'h11, 0, 0, 0, 0);
        step(1, 16'hC010, 8'h22, 1, 0, 0, 0);
        chk("filt_count", 32'(count_o), 0);
        chk("rd_count", 32'(count_r), 1);
        chk("rd_addr", 32'(addr_r), 32'hC010);
        chk("rd_rw", 32'(rw_r), 1);
        step(0, 0, 0, 0, 1, 0, 0);
        chk("rd_drain", 32'(count_r), 0);
        // fill and overflow
        for (int i = 0; i < 16; i++) step(1, 16'hC080 + 16'(i), 8'(i), 0, 0, 0, 0);
        chk("full_count", 32'(count_o), 16);
        for (int i = 0; i < 3; i++) step(1, 16'hC090, 8'hEE, 0, 0, 0, 0);
        chk("ovf_set", 32'(ovf), 1);
        chk("ovf_drops", 32'(drop_o), 3);
        // full with simultaneous push and pop
        step(1, 16'hC0FF, 8'h5A, 0, 1, 0, 0);
        chk("pp_count", 32'(count_o), 16);
        chk("pp_drops", 32'(drop_o), 3);
        for (int i = 0; i < 16; i++) begin
            chk("order", 32'(addr_o), i == 15 ? 32'hC0FF : 32'hC081 + i);
            step(0, 0, 0, 0, 1, 0, 0);
        end
        chk("drained", 32'(count_o), 0);
        // flush race then clear/drop race
        for (int i = 0; i < 5; i++) step(1, 16'hC020 + 16'(i), 8'(i), 0, 0, 0, 0);
        chk("pre_flush", 32'(count_o), 5);
        step(1, 16'hC030, 8'h77, 0, 0, 1, 0);
        chk("flush_count", 32'(count_o), 0);
        chk("flush_drops", 32'(drop_o), 3);
        for (int i = 0; i < 16; i++) step(1, 16'hC040 + 16'(i), 8'(i), 0, 0, 0, 0);
        step(1, 16'hC050, 8'h99, 0, 0, 0, 1);
        chk("clr_ovf", 32'(ovf), 1);
        chk("clr_drops", 32'(drop_o), 1);
        // async reset mid-operation
        step(0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 7; i++) step(1, 16'hC060 + 16'(i), 8'(i), 0, 0, 0, 0);
        chk("pre_rst_count", 32'(count_o), 7);
        chk("pre_rst_ovf", 32'(ovf), 1);
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("arst_count", 32'(count_o), 0);
        chk("arst_valid", 32'(valid), 0);
        chk("arst_ovf", 32'(ovf), 0);
        chk("arst_drop", 32'(drop_o), 0);
        @(negedge clk);
        rst_n = 1;
        step(1, 16'hC001, 8'h42, 0, 0, 0, 0);
        chk("post_count", 32'(count_o), 1);
        chk("post_addr", 32'(addr_o), 32'hC001);
        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
